// File: rtl/fdu_pkg.sv
// fdu_pkg: shared FSM encoding, instruction type codes and IR field positions for fetch_decode_unit
package fdu_pkg;
  localparam int IR_W = 32;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  localparam logic [2:0] TY_ALU  = 3'b000;
  localparam logic [2:0] TY_ALUI = 3'b001;
  localparam logic [2:0] TY_MEM  = 3'b010;
  localparam logic [2:0] TY_BR   = 3'b100;
  localparam logic [2:0] TY_SYS  = 3'b110;
  // One bit per 3-bit type code; a set bit marks a legal type.
  localparam logic [7:0] LEGAL_MASK = (8'd1 << TY_ALU) | (8'd1 << TY_ALUI) | (8'd1 << TY_MEM) |
                                      (8'd1 << TY_BR) | (8'd1 << TY_SYS);
  localparam int TYPE_LSB = 29;
  localparam int OP_LSB   = 24;
  localparam int RD_LSB   = 20;
  localparam int RA_LSB   = 16;
  localparam int RB_LSB   = 12;
  localparam int IMM_LSB  = 0;
  function automatic logic is_legal(input logic [2:0] t);
    return LEGAL_MASK[t];
  endfunction
endpackage

// File: rtl/fdu_if.sv
// fdu_if: instruction-memory bus; master = fetch unit (drives IM_REQ/IM_ADDR), slave = memory (drives IM_ACK/IM_DATA)
interface fdu_if import fdu_pkg::*; #(parameter int PC_W = 16);
  logic            IM_REQ;
  logic [PC_W-1:0] IM_ADDR;
  logic            IM_ACK;
  logic [IR_W-1:0] IM_DATA;
  modport master (output IM_REQ, IM_ADDR, input IM_ACK, IM_DATA);
  modport slave  (input IM_REQ, IM_ADDR, output IM_ACK, IM_DATA);
endinterface

// File: rtl/fdu_pc_next.sv
// fdu_pc_next: next-PC adder, pc+1 (sel=0) or pc+sign-extended imm (sel=1), modulo 2^PC_W
// ports: pc, imm[15:0], sel in; pc_nxt out
module fdu_pc_next #(parameter int PC_W = 16) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  input  logic            sel,
  output logic [PC_W-1:0] pc_nxt
);
  assign pc_nxt = pc + (sel ? PC_W'($signed(imm)) : PC_W'(1));
endmodule

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: edge-triggered instruction fetch over fdu_if plus combinational IR field decode
// ports: CLK, RST_N (sync, active-low), W_IM fetch strobe, W_PC pc-write strobe, S_MXPC pc source,
//        im (fdu_if.master), IR_VALID, TYPE/OP/RD/RA/RB/IMM decoded fields, PC, ILLEGAL
// optional: define FDU_ILLEGAL_DETECT_EN to flag illegal instruction types on ILLEGAL
module fetch_decode_unit import fdu_pkg::*; #(parameter int PC_W = 16) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            W_IM,
  input  logic            W_PC,
  input  logic            S_MXPC,
  fdu_if.master           im,
  output logic            IR_VALID,
  output logic [2:0]      TYPE,
  output logic [4:0]      OP,
  output logic [3:0]      RD,
  output logic [3:0]      RA,
  output logic [3:0]      RB,
  output logic [15:0]     IMM,
  output logic [PC_W-1:0] PC,
  output logic            ILLEGAL
);
  state_t          state, state_nxt;
  logic            w_im_q, w_pc_q, im_edge, pc_edge;
  logic            in_fetch, ack, start, pend_set, fetch_pend, pc_upd;
  logic            def_valid, def_sel, nx_sel;
  logic [15:0]     def_imm, nx_imm;
  logic [IR_W-1:0] ir;
  logic [PC_W-1:0] pc_nxt;
  assign im_edge  = W_IM & ~w_im_q;
  assign pc_edge  = W_PC & ~w_pc_q;
  assign in_fetch = state == FETCH;
  assign ack      = in_fetch & im.IM_ACK;
  // Coincident fetch and pc-write: update PC now, launch the fetch one cycle later.
  assign pend_set = ~in_fetch & im_edge & pc_edge;
  assign start    = ~in_fetch & (fetch_pend | (im_edge & ~pc_edge));
  // A pc-write seen in FETCH is parked and applied at the ACK edge; a fresh edge on the ACK cycle wins.
  assign pc_upd   = (~in_fetch & pc_edge) | (ack & (pc_edge | def_valid));
  assign nx_sel   = (in_fetch & ~pc_edge) ? def_sel : S_MXPC;
  assign nx_imm   = (in_fetch & ~pc_edge) ? def_imm : IMM;
  fdu_pc_next #(.PC_W(PC_W)) u_pc_next (.pc(PC), .imm(nx_imm), .sel(nx_sel), .pc_nxt(pc_nxt));
  always_comb state_nxt = start ? FETCH : ack ? HOLD : state;
  always_ff @(posedge CLK) state <= !RST_N ? IDLE : state_nxt;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      w_im_q     <= 1'b0;
      w_pc_q     <= 1'b0;
      fetch_pend <= 1'b0;
      PC         <= '0;
      ir         <= '0;
      IR_VALID   <= 1'b0;
      def_valid  <= 1'b0;
      def_sel    <= 1'b0;
      def_imm    <= '0;
    end else begin
      w_im_q     <= W_IM;
      w_pc_q     <= W_PC;
      fetch_pend <= pend_set;
      def_valid  <= in_fetch & ~ack & (pc_edge | def_valid);
      if (pc_upd) PC <= pc_nxt;
      if (start) IR_VALID <= 1'b0;
      else if (ack) begin
        ir       <= im.IM_DATA;
        IR_VALID <= 1'b1;
      end
      if (in_fetch & pc_edge) begin
        def_sel <= S_MXPC;
        def_imm <= IMM;
      end
    end
  end
`ifdef FDU_ILLEGAL_DETECT_EN
  logic illegal_q;
  always_ff @(posedge CLK) begin
    if (!RST_N) illegal_q <= 1'b0;
    else if (start) illegal_q <= 1'b0;
    else if (ack) illegal_q <= ~is_legal(im.IM_DATA[TYPE_LSB +: 3]);
  end
  assign ILLEGAL = illegal_q;
`else
  assign ILLEGAL = 1'b0;
`endif
  assign im.IM_REQ  = in_fetch;
  assign im.IM_ADDR = PC;
  assign TYPE = ir[TYPE_LSB +: 3];
  assign OP   = ir[OP_LSB +: 5];
  assign RD   = ir[RD_LSB +: 4];
  assign RA   = ir[RA_LSB +: 4];
  assign RB   = ir[RB_LSB +: 4];
  assign IMM  = ir[IMM_LSB +: 16];
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: directed self-checking bench for fetch_decode_unit
module tb_fetch_decode_unit;
  logic        CLK, RST_N, W_IM, W_PC, S_MXPC;
  logic        IR_VALID, ILLEGAL;
  logic [2:0]  TYPE;
  logic [4:0]  OP;
  logic [3:0]  RD, RA, RB;
  logic [15:0] IMM, PC;
  int tests = 0;
  int fails = 0;
  fdu_if #(.PC_W(16)) bus ();
  fetch_decode_unit #(.PC_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .W_IM(W_IM), .W_PC(W_PC), .S_MXPC(S_MXPC), .im(bus),
    .IR_VALID(IR_VALID), .TYPE(TYPE), .OP(OP), .RD(RD), .RA(RA), .RB(RB),
    .IMM(IMM), .PC(PC), .ILLEGAL(ILLEGAL)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic do_fetch(input logic [31:0] data);
    W_IM = 1'b1;
    tick();
    W_IM = 1'b0;
    bus.IM_ACK = 1'b1;
    bus.IM_DATA = data;
    tick();
    bus.IM_ACK = 1'b0;
  endtask
  task automatic pulse_wpc(input logic sel);
    S_MXPC = sel;
    W_PC = 1'b1;
    tick();
    W_PC = 1'b0;
    tick();
  endtask
  task automatic test_reset;
    RST_N = 1'b0; W_IM = 1'b0; W_PC = 1'b0; S_MXPC = 1'b0;
    bus.IM_ACK = 1'b0; bus.IM_DATA = '0;
    repeat (3) tick();
    tests++; if (IR_VALID !== 1'b0) begin fails++; $display("FAIL rst_ir_valid got %b exp 0", IR_VALID); end
    tests++; if (bus.IM_REQ !== 1'b0) begin fails++; $display("FAIL rst_im_req got %b exp 0", bus.IM_REQ); end
    tests++; if (PC !== 16'h0) begin fails++; $display("FAIL rst_pc got %h exp 0000", PC); end
    tests++; if ({TYPE, OP, RD, RA, IMM} !== 32'h0) begin fails++; $display("FAIL rst_ir got %h exp 0", {TYPE, OP, RD, RA, IMM}); end
    tests++; if (ILLEGAL !== 1'b0) begin fails++; $display("FAIL rst_illegal got %b exp 0", ILLEGAL); end
  endtask
  task automatic test_basic_fetch;
    RST_N = 1'b1;
    W_IM = 1'b1;
    tick();
    W_IM = 1'b0;
    tests++; if (bus.IM_REQ !== 1'b1 || bus.IM_ADDR !== 16'h0) begin fails++; $display("FAIL basic_req got req=%b addr=%h exp req=1 addr=0000", bus.IM_REQ, bus.IM_ADDR); end
    tests++; if (IR_VALID !== 1'b0) begin fails++; $display("FAIL basic_valid_early got %b exp 0", IR_VALID); end
    bus.IM_ACK = 1'b1; bus.IM_DATA = 32'h2A31_2000;
    tick();
    bus.IM_ACK = 1'b0;
    tests++; if (IR_VALID !== 1'b1 || bus.IM_REQ !== 1'b0) begin fails++; $display("FAIL basic_latch got valid=%b req=%b exp valid=1 req=0", IR_VALID, bus.IM_REQ); end
    tests++; if ({TYPE, OP, RD, RA, RB} !== {3'b001, 5'b01010, 4'd3, 4'd1, 4'd2}) begin fails++; $display("FAIL basic_fields got t=%b op=%b rd=%0d ra=%0d rb=%0d exp t=001 op=01010 rd=3 ra=1 rb=2", TYPE, OP, RD, RA, RB); end
    tests++; if (IMM !== 16'h2000) begin fails++; $display("FAIL basic_imm got %h exp 2000", IMM); end
  endtask
  task automatic test_ack_delay;
    W_IM = 1'b1;
    tick();
    W_IM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.IM_ACK = (i == 3);
      bus.IM_DATA = (i == 3) ? 32'h0C45_6789 : 32'hFFFF_FFFF;
      W_IM = (i == 1);
      tests++; if (bus.IM_REQ !== 1'b1 || bus.IM_ADDR !== 16'h0) begin fails++; $display("FAIL delay_hold%0d got req=%b addr=%h exp req=1 addr=0000", i, bus.IM_REQ, bus.IM_ADDR); end
      tick();
    end
    W_IM = 1'b0; bus.IM_ACK = 1'b0;
    tests++; if (IR_VALID !== 1'b1 || {TYPE, OP, RD, RA, RB, IMM} !== {3'b000, 5'h0C, 4'd4, 4'd5, 4'd6, 16'h6789}) begin fails++; $display("FAIL delay_latch got v=%b t=%b op=%h rd=%0d ra=%0d rb=%0d imm=%h", IR_VALID, TYPE, OP, RD, RA, RB, IMM); end
    tick();
    tests++; if (bus.IM_REQ !== 1'b0) begin fails++; $display("FAIL delay_no_second_req got %b exp 0", bus.IM_REQ); end
    bus.IM_ACK = 1'b1; bus.IM_DATA = 32'hDEAD_BEEF;
    tick();
    bus.IM_ACK = 1'b0;
    tests++; if (IMM !== 16'h6789 || OP !== 5'h0C) begin fails++; $display("FAIL stray_ack_ir got op=%h imm=%h exp op=0c imm=6789", OP, IMM); end
  endtask
  task automatic test_pc_arith;
    do_fetch(32'h0000_FFFF);
    pulse_wpc(1'b1);
    tests++; if (PC !== 16'hFFFF) begin fails++; $display("FAIL pc_neg_wrap got %h exp ffff", PC); end
    pulse_wpc(1'b0);
    tests++; if (PC !== 16'h0000) begin fails++; $display("FAIL pc_inc_wrap got %h exp 0000", PC); end
    repeat (5) pulse_wpc(1'b0);
    tests++; if (PC !== 16'h0005) begin fails++; $display("FAIL pc_inc5 got %h exp 0005", PC); end
    do_fetch(32'h0000_FFFD);
    pulse_wpc(1'b1);
    tests++; if (PC !== 16'h0002) begin fails++; $display("FAIL pc_branch got %h exp 0002", PC); end
  endtask
  task automatic test_deferred;
    pulse_wpc(1'b0);
    pulse_wpc(1'b0);
    W_IM = 1'b1;
    tick();
    W_IM = 1'b0;
    W_PC = 1'b1; S_MXPC = 1'b0;
    tick();
    W_PC = 1'b0;
    tests++; if (PC !== 16'h4 || bus.IM_ADDR !== 16'h4 || bus.IM_REQ !== 1'b1) begin fails++; $display("FAIL defer_hold got pc=%h addr=%h req=%b exp pc=4 addr=4 req=1", PC, bus.IM_ADDR, bus.IM_REQ); end
    tick();
    bus.IM_ACK = 1'b1; bus.IM_DATA = 32'h0000_0003;
    tests++; if (PC !== 16'h4) begin fails++; $display("FAIL defer_ack_cycle got %h exp 0004", PC); end
    tick();
    bus.IM_ACK = 1'b0;
    tests++; if (PC !== 16'h5) begin fails++; $display("FAIL defer_apply got %h exp 0005", PC); end
    W_IM = 1'b1;
    tick();
    W_IM = 1'b0;
    W_PC = 1'b1; S_MXPC = 1'b0;
    tick();
    W_PC = 1'b0;
    tick();
    W_PC = 1'b1; S_MXPC = 1'b1;
    tick();
    W_PC = 1'b0;
    bus.IM_ACK = 1'b1; bus.IM_DATA = 32'h0000_0010;
    tick();
    bus.IM_ACK = 1'b0;
    tests++; if (PC !== 16'h8) begin fails++; $display("FAIL defer_overwrite got %h exp 0008", PC); end
  endtask
  task automatic test_same_cycle;
    W_IM = 1'b1; W_PC = 1'b1; S_MXPC = 1'b0;
    tick();
    W_IM = 1'b0; W_PC = 1'b0;
    tests++; if (PC !== 16'h9 || bus.IM_REQ !== 1'b0) begin fails++; $display("FAIL same_pc_first got pc=%h req=%b exp pc=9 req=0", PC, bus.IM_REQ); end
    tick();
    tests++; if (bus.IM_REQ !== 1'b1 || bus.IM_ADDR !== 16'h9 || IR_VALID !== 1'b0) begin fails++; $display("FAIL same_fetch got req=%b addr=%h v=%b exp req=1 addr=9 v=0", bus.IM_REQ, bus.IM_ADDR, IR_VALID); end
    bus.IM_ACK = 1'b1; bus.IM_DATA = 32'hE000_0000;
    tick();
    bus.IM_ACK = 1'b0;
`ifdef FDU_ILLEGAL_DETECT_EN
    tests++; if (TYPE !== 3'b111 || ILLEGAL !== 1'b1) begin fails++; $display("FAIL illegal_type got t=%b ill=%b exp t=111 ill=1", TYPE, ILLEGAL); end
`else
    tests++; if (TYPE !== 3'b111 || ILLEGAL !== 1'b0) begin fails++; $display("FAIL illegal_type got t=%b ill=%b exp t=111 ill=0", TYPE, ILLEGAL); end
`endif
  endtask
  task automatic test_reset_in_fetch;
    W_IM = 1'b1;
    tick();
    W_IM = 1'b0;
    RST_N = 1'b0; bus.IM_ACK = 1'b1; bus.IM_DATA = 32'hFFFF_FFFF;
    tick();
    RST_N = 1'b1; bus.IM_ACK = 1'b0;
    tests++; if (bus.IM_REQ !== 1'b0 || IR_VALID !== 1'b0 || ILLEGAL !== 1'b0) begin fails++; $display("FAIL rstf_state got req=%b v=%b ill=%b exp 0 0 0", bus.IM_REQ, IR_VALID, ILLEGAL); end
    tests++; if ({TYPE, OP, RD, RA, IMM} !== 32'h0 || PC !== 16'h0) begin fails++; $display("FAIL rstf_ir got ir=%h pc=%h exp 0 0", {TYPE, OP, RD, RA, IMM}, PC); end
    tick();
    tests++; if (bus.IM_REQ !== 1'b0) begin fails++; $display("FAIL rstf_idle got %b exp 0", bus.IM_REQ); end
  endtask
  initial begin
    test_reset();
    test_basic_fetch();
    test_ack_delay();
    test_pc_arith();
    test_deferred();
    test_same_cycle();
    test_reset_in_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
